// File: rtl/audio_output_stream.sv
// Sample FIFO between a CPU writer and an Avalon-ST codec sink, with prefill and underrun handling.
// Optional AUDIO_OUT_HOLD_LAST_EN: repeat the last popped sample instead of silence when starved.
module audio_output_stream #(
   parameter int DEPTH   = 16,
   parameter int PREFILL = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     write_req,
   input  logic [31:0]              write_data,
   output logic                     write_ready,
   input  logic                     play_en,
   input  logic                     flush,
   output logic [15:0]              dac_data,
   output logic                     dac_valid,
   input  logic                     dac_ready,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic [15:0]              underrun_cnt,
   output logic [1:0]               state
);

   // state  | meaning
   // IDLE   | playback disabled, sink sees no valid data
   // FILL   | waiting for PREFILL samples, sink is fed the filler
   // STREAM | FIFO head is streamed to the sink
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL    = (AW+1)'(DEPTH);
   localparam logic [AW:0] PREFILL_LVL = (AW+1)'(PREFILL);

   state_t           state_q, state_d;
   logic [15:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop, underrun, in_stream, fifo_empty;
   logic [15:0]      head, filler;
   logic             unused_ok;

   assign unused_ok   = ^write_data[31:16];
   assign in_stream   = (state_q == STREAM);
   assign fifo_empty  = (fill_level == '0);
   assign write_ready = (fill_level != FULL_LVL);
   assign push        = write_req & write_ready & ~flush;
   assign pop         = in_stream & dac_ready & ~fifo_empty & ~flush;
   assign underrun    = in_stream & dac_ready & fifo_empty;
   assign head        = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= write_data[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill_level <= fill_level + 1'b1;
            2'b01:   fill_level <= fill_level - 1'b1;
            default: fill_level <= fill_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   underrun_cnt <= '0;
      else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
   end

`ifdef AUDIO_OUT_HOLD_LAST_EN
   // Flush deliberately leaves the held sample alone so the output stays continuous.
   logic [15:0] hold_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      hold_q <= '0;
      else if (pop) hold_q <= head;
   end
   assign filler = hold_q;
`else
   assign filler = 16'h0000;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!play_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = FILL;
            FILL:    if (fill_level >= PREFILL_LVL) state_d = STREAM;
            STREAM:  if (underrun) state_d = FILL;
            default: state_d = IDLE;
         endcase
      end
   end

   assign state     = state_q;
   assign dac_valid = (state_q != IDLE);
   assign dac_data  = (in_stream && !fifo_empty) ? head : filler;

endmodule

// File: tb/tb_audio_output_stream.sv
// Directed bench for audio_output_stream: vector table for prefill/stream/underrun, hand sequences for the rest.
module tb_audio_output_stream;

`ifdef AUDIO_OUT_HOLD_LAST_EN
   localparam logic [15:0] FILLER_EXP = 16'h0008;
`else
   localparam logic [15:0] FILLER_EXP = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        write_req;
   logic [31:0] write_data;
   logic        write_ready;
   logic        play_en;
   logic        flush;
   logic [15:0] dac_data;
   logic        dac_valid;
   logic        dac_ready;
   logic [4:0]  fill_level;
   logic [15:0] underrun_cnt;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   audio_output_stream #(.DEPTH(16), .PREFILL(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .write_req    (write_req),
      .write_data   (write_data),
      .write_ready  (write_ready),
      .play_en      (play_en),
      .flush        (flush),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid),
      .dac_ready    (dac_ready),
      .fill_level   (fill_level),
      .underrun_cnt (underrun_cnt),
      .state        (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] wdata;
      logic        play;
      logic        rdy;
      logic [4:0]  fill;
      logic [1:0]  st;
      logic [15:0] data;
      logic        valid;
      logic        wready;
      logic [15:0] ucnt;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic wr, logic [31:0] wdata, logic [4:0] fill, logic [1:0] st,
                               logic [15:0] data, logic [15:0] ucnt);
      vec_t v;
      v.wr = wr; v.wdata = wdata; v.play = 1'b1; v.rdy = 1'b1;
      v.fill = fill; v.st = st; v.data = data; v.valid = 1'b1;
      v.wready = 1'b1; v.ucnt = ucnt;
      return v;
   endfunction

   initial begin
      // prefill: 8 pushes in FILL, then STREAM, 8 pops, then one underrun handshake
      for (int i = 0; i < 8; i++)
         vecs[i] = mk(1'b1, 32'hDEAD_0000 | (i + 1), 5'(i + 1), 2'd1, 16'h0000, 16'd0);
      vecs[8] = mk(1'b0, 32'h0, 5'd8, 2'd2, 16'h0001, 16'd0);
      for (int k = 9; k < 16; k++)
         vecs[k] = mk(1'b0, 32'h0, 5'(16 - k), 2'd2, 16'(k - 7), 16'd0);
      vecs[16] = mk(1'b0, 32'h0, 5'd0, 2'd2, FILLER_EXP, 16'd0);
      vecs[17] = mk(1'b0, 32'h0, 5'd0, 2'd1, FILLER_EXP, 16'd1);

      rst = 1'b1; write_req = 1'b0; write_data = '0; play_en = 1'b0;
      flush = 1'b0; dac_ready = 1'b0;
      step(); step();
      chk("rst.state",  32'(state), 32'd0);
      chk("rst.fill",   32'(fill_level), 32'd0);
      chk("rst.valid",  32'(dac_valid), 32'd0);
      chk("rst.data",   32'(dac_data), 32'h0);
      chk("rst.wready", 32'(write_ready), 32'd1);
      chk("rst.ucnt",   32'(underrun_cnt), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         write_req = vecs[i].wr; write_data = vecs[i].wdata;
         play_en = vecs[i].play; dac_ready = vecs[i].rdy;
         step();
         chk($sformatf("v%0d.fill", i),   32'(fill_level),   32'(vecs[i].fill));
         chk($sformatf("v%0d.state", i),  32'(state),        32'(vecs[i].st));
         chk($sformatf("v%0d.data", i),   32'(dac_data),     32'(vecs[i].data));
         chk($sformatf("v%0d.valid", i),  32'(dac_valid),    32'(vecs[i].valid));
         chk($sformatf("v%0d.wready", i), 32'(write_ready),  32'(vecs[i].wready));
         chk($sformatf("v%0d.ucnt", i),   32'(underrun_cnt), 32'(vecs[i].ucnt));
      end

      // full: 17 pushes while idle
      write_req = 1'b0; play_en = 1'b0; dac_ready = 1'b0;
      step();
      chk("full.idle_state", 32'(state), 32'd0);
      chk("full.idle_valid", 32'(dac_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         write_req = 1'b1; write_data = {16'hABCD, 16'h0100 + 16'(i)};
         step();
         chk($sformatf("full.fill%0d", i), 32'(fill_level), 32'(i + 1));
         chk($sformatf("full.wready%0d", i), 32'(write_ready), (i == 15) ? 32'd0 : 32'd1);
      end
      write_data = 32'h0000_01FF;
      step();
      chk("full.17th_fill", 32'(fill_level), 32'd16);
      chk("full.17th_wready", 32'(write_ready), 32'd0);
      write_req = 1'b0;

      // resume with retained contents, then backpressure
      play_en = 1'b1;
      step();
      chk("resume.fill_state", 32'(state), 32'd1);
      step();
      chk("resume.stream_state", 32'(state), 32'd2);
      chk("resume.head", 32'(dac_data), 32'h0100);
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("bp.data%0d", i), 32'(dac_data), 32'h0100);
         chk($sformatf("bp.fill%0d", i), 32'(fill_level), 32'd16);
      end
      dac_ready = 1'b1;
      step();
      chk("pop.fill", 32'(fill_level), 32'd15);
      chk("pop.data", 32'(dac_data), 32'h0101);
      chk("pop.wready", 32'(write_ready), 32'd1);
      write_req = 1'b1; write_data = 32'h0000_0300;
      step();
      chk("pushpop.fill", 32'(fill_level), 32'd15);
      chk("pushpop.data", 32'(dac_data), 32'h0102);
      write_req = 1'b0; dac_ready = 1'b0;

      // flush, then flush colliding with a push
      play_en = 1'b0;
      step();
      chk("stop.state", 32'(state), 32'd0);
      chk("stop.fill", 32'(fill_level), 32'd15);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush.fill", 32'(fill_level), 32'd0);
      chk("flush.ucnt", 32'(underrun_cnt), 32'd1);
      for (int i = 0; i < 5; i++) begin
         write_req = 1'b1; write_data = 32'h0400 + i;
         step();
      end
      chk("coll.pre_fill", 32'(fill_level), 32'd5);
      flush = 1'b1; write_data = 32'h0000_0999;
      step();
      flush = 1'b0; write_req = 1'b0;
      chk("coll.fill", 32'(fill_level), 32'd0);
      step();
      chk("coll.fill_after", 32'(fill_level), 32'd0);
      for (int i = 0; i < 8; i++) begin
         write_req = 1'b1; write_data = 32'h0200 + i;
         step();
      end
      write_req = 1'b0;
      chk("coll.refill", 32'(fill_level), 32'd8);
      play_en = 1'b1;
      step(); step();
      chk("coll.state", 32'(state), 32'd2);
      chk("coll.head", 32'(dac_data), 32'h0200);

      // reset mid-stream
      dac_ready = 1'b1;
      step(); step();
      chk("mid.fill", 32'(fill_level), 32'd6);
      chk("mid.data", 32'(dac_data), 32'h0202);
      #2 rst = 1'b1;
      #1;
      chk("rstmid.state", 32'(state), 32'd0);
      chk("rstmid.fill", 32'(fill_level), 32'd0);
      chk("rstmid.valid", 32'(dac_valid), 32'd0);
      chk("rstmid.ucnt", 32'(underrun_cnt), 32'd0);
      chk("rstmid.data", 32'(dac_data), 32'h0);
      chk("rstmid.wready", 32'(write_ready), 32'd1);
      step();
      rst = 1'b0; play_en = 1'b0; dac_ready = 1'b0;
      write_req = 1'b1; write_data = 32'h0000_0777;
      step();
      write_req = 1'b0;
      chk("post_rst.fill", 32'(fill_level), 32'd1);
      play_en = 1'b1;
      step();
      chk("post_rst.state", 32'(state), 32'd1);
      chk("post_rst.filler", 32'(dac_data), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/audio_output_stream.md
AUDIO_OUTPUT_STREAM -- requirements
Module: audio_output_stream

Interface
REQ-001 SHALL have parameter DEPTH, default 16; FIFO depth in 16-bit samples; power of two, at least 4.
REQ-002 SHALL have parameter PREFILL, default 8; samples required before streaming starts; range 1..DEPTH.
REQ-003 SHALL have port clk, input, 1 bit; the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port write_req, input, 1; CPU requests to push a sample.
REQ-006 SHALL have port write_data, input, 32; CPU sample; bits [15:0] are used and [31:16] are ignored.
REQ-007 SHALL have port write_ready, output, 1; high when the FIFO can accept a push.
REQ-008 SHALL have port play_en, input, 1; level-sensitive playback enable.
REQ-009 SHALL have port flush, input, 1; one-cycle pulse that empties the FIFO.
REQ-010 SHALL have port dac_data, output, 16; sample driven to the codec channel sink.
REQ-011 SHALL have port dac_valid, output, 1; Avalon-ST valid toward the codec.
REQ-012 SHALL have port dac_ready, input, 1; Avalon-ST ready from the codec.
REQ-013 SHALL have port fill_level, output, log2(DEPTH)+1; current FIFO occupancy.
REQ-014 SHALL have port underrun_cnt, output, 16; count of underruns, saturating.
REQ-015 SHALL have port state, output, 2; FSM state, encoded IDLE=0, FILL=1, STREAM=2.

Function
REQ-016 SHALL accept a push when write_req && write_ready, storing write_data[15:0] at the tail; the sample is visible at the head the next cycle.
REQ-017 SHALL drive write_ready = (fill_level != DEPTH), with no same-cycle pop bypass; write_ready stays low when full, even if a pop occurs that cycle.
REQ-018 SHALL pop only in STREAM, only when dac_valid && dac_ready, and only if fill_level != 0.
REQ-019 SHALL handle a simultaneous push and pop by leaving fill_level unchanged; pointers wrap modulo DEPTH.
REQ-020 SHALL apply flush with priority over any push or pop in the same cycle: pointers and fill_level go to 0; underrun_cnt and the FSM state are unaffected.
REQ-021 SHALL run an FSM with the following transitions:
- IDLE -> FILL when play_en=1.
- FILL -> STREAM when play_en=1 and fill_level >= PREFILL.
- STREAM -> FILL on an underrun.
- Any state -> IDLE when play_en=0, taking priority.
REQ-022 SHALL drive dac_valid=0 in IDLE and dac_valid=1 in FILL and STREAM.
REQ-023 SHALL drive dac_data as follows:
- STREAM with a non-empty FIFO: the FIFO head.
- All other cases: the filler sample (see REQ-030).
REQ-024 SHALL register an underrun when in STREAM with dac_ready=1 and fill_level=0: the filler is consumed, underrun_cnt increments and saturates at 16'hFFFF, and the next state is FILL.
REQ-025 SHALL retain FIFO contents when play_en falls; resuming re-enters FILL and streams immediately if fill_level >= PREFILL.
REQ-026 SHALL keep dac_data stable while dac_valid=1 and dac_ready=0.

Reset
REQ-027 SHALL set the following on rst, asynchronously:
- state = IDLE;
- FIFO pointers, fill_level and underrun_cnt = 0;
- dac_valid = 0 and dac_data = 16'h0000;
- write_ready = 1;
- held sample (REQ-030) = 0.
REQ-028 SHALL recover so that the first push is accepted on the first clock edge after rst is released.
REQ-029 SHALL abandon any in-progress stream on a reset during STREAM; no sample is popped on the edge where rst is asserted.

Configuration
REQ-030 SHALL support macro AUDIO_OUT_HOLD_LAST_EN:
- When defined, the filler is the most recently popped sample, held in a register that resets to 0 and is not cleared by flush.
- When undefined, the filler is 16'h0000 and no hold register exists.

Verification
REQ-031 SHALL cover prefill:
- Stimulus: PREFILL=8, play_en=1, push 0x0001..0x0008, dac_ready=1.
- Response: state goes FILL -> STREAM the cycle after the 8th push; dac_data emits 0x0001..0x0008 in order.
REQ-032 SHALL cover full:
- Stimulus: DEPTH=16, play_en=0, push 17 samples.
- Response: write_ready=0 after the 16th; the 17th is not accepted; fill_level=16.
REQ-033 SHALL cover underrun:
- Stimulus: stream 8 samples with dac_ready=1, no further pushes.
- Response: on the 9th handshake underrun_cnt=1 and state=FILL; dac_data=0x0008 with AUD​IO_OUT_HOLD_LAST_EN defined, 0x0000 without it.
REQ-034 SHALL cover flush collision:
- Stimulus: fill_level=5, flush=1 together with write_req=1.
- Response: fill_level=0 next cycle; the pushed sample is discarded.
REQ-035 SHALL cover backpressure:
- Stimulus: in STREAM, hold dac_ready=0 for 10 cycles.
- Response: dac_data is unchanged and fill_level is unchanged.
REQ-036 SHALL cover reset mid-stream:
- Stimulus: assert rst in STREAM with fill_level=6.
- Response: immediately state=IDLE, fill_level=0, dac_valid=0, underrun_cnt=0.
